// File: rtl/interrupt_controller_if.sv
// CPU-side bundle between the interrupt controller and the major-state sequencer/datapath.
// master drives instruction, strobes and device flags; slave returns request, enable and pulses.
interface interrupt_controller_if #(
    parameter int NDEV = 8
);
    logic [0:11]     instruction;
    logic            iot_exec;
    logic            instr_done;
    logic            int_ack;
    logic [NDEV-1:0] dev_req;
    logic            int_req;
    logic            int_ena;
    logic            int_inh;
    logic            skip;
    logic            caf_clr;
    logic [3:0]      irq_id;
    logic            irq_valid;

    modport master (
        output instruction, iot_exec, instr_done, int_ack, dev_req,
        input  int_req, int_ena, int_inh, skip, caf_clr, irq_id, irq_valid
    );

    modport slave (
        input  instruction, iot_exec, instr_done, int_ack, dev_req,
        output int_req, int_ena, int_inh, skip, caf_clr, irq_id, irq_valid
    );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt system: masked request combine, ION/IOF enable FSM with one-instruction ION delay, CIF/CDI inhibit.
// Latency: all outputs registered, one cycle after the triggering input edge.
// Backpressure: none; strobes are single-cycle pulses and are never held off.
module interrupt_controller #(
    parameter int              NDEV     = 8,
    parameter logic [NDEV-1:0] DEV_MASK = '1
) (
    input logic                  clk,
    input logic                  reset,
    interrupt_controller_if.slave bus
);
    typedef enum logic [1:0] {IOFF, ARMED, ION} state_t;

    state_t          state;
    logic [NDEV-1:0] masked;
    logic [3:0]      lowest_id;
    logic [2:0]      iot_op;
    logic            cpu_iot;
    logic            cif_cdi;
    logic            jump_done;

    assign masked  = bus.dev_req & DEV_MASK;
    assign iot_op  = bus.instruction[9:11];
    assign cpu_iot = bus.iot_exec && (bus.instruction[0:8] == 9'o600);
    assign cif_cdi = bus.iot_exec && (bus.instruction[0:5] == 6'o62)
                     && (iot_op == 3'o2 || iot_op == 3'o3);
    assign jump_done = bus.instr_done
                       && (bus.instruction[0:2] == 3'b100 || bus.instruction[0:2] == 3'b101);

    assign bus.int_ena = (state == ION);

    always_comb begin
        lowest_id = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (masked[i]) lowest_id = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IOFF;
            bus.int_req   <= 1'b0;
            bus.irq_valid <= 1'b0;
            bus.irq_id    <= '0;
            bus.int_inh   <= 1'b0;
            bus.skip      <= 1'b0;
            bus.caf_clr   <= 1'b0;
        end else begin
            bus.int_req   <= |masked;
            bus.irq_valid <= |masked;
            bus.irq_id    <= lowest_id;
            bus.skip      <= 1'b0;
            bus.caf_clr   <= 1'b0;

            if (bus.int_ack) begin
                state       <= IOFF;
                bus.int_inh <= 1'b0;
            end else begin
                // Arming completes on any later instr_done; IOT decode below overrides it.
                if (bus.instr_done && state == ARMED) state <= ION;

                if (cpu_iot) begin
                    case (iot_op)
                        3'o0: begin
                            bus.skip <= (state == ION);
                            state    <= IOFF;
                        end
                        3'o1: begin
                            // The ION's own instr_done must not complete the delay.
                            if (state == IOFF) state <= ARMED;
                            else               state <= state;
                        end
                        3'o2: state <= IOFF;
                        3'o3: bus.skip <= bus.int_req;
                        3'o7: begin
                            state       <= IOFF;
                            bus.caf_clr <= 1'b1;
                        end
                        default: ;
                    endcase
                end

                if (cif_cdi) bus.int_inh <= 1'b1;
                if (jump_done || (cpu_iot && iot_op == 3'o7)) bus.int_inh <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with DEV_MASK=8'hF7; expected values are hand-computed.
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    interrupt_controller_if #(.NDEV(8)) bus ();

    interrupt_controller #(.NDEV(8), .DEV_MASK(8'hF7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle with an executing IOT; done models the IOT's own last cycle.
    task automatic iot_step(input logic [11:0] ins, input logic done);
        bus.instruction = ins;
        bus.iot_exec    = 1'b1;
        bus.instr_done  = done;
        cyc();
        bus.iot_exec    = 1'b0;
        bus.instr_done  = 1'b0;
    endtask

    task automatic done_step(input logic [11:0] ins);
        bus.instruction = ins;
        bus.instr_done  = 1'b1;
        cyc();
        bus.instr_done  = 1'b0;
    endtask

    task automatic go_ion();
        iot_step(12'o6001, 1'b1);
        done_step(12'o1234);
    endtask

    initial begin
        reset           = 1'b1;
        bus.instruction = 12'o0000;
        bus.iot_exec    = 1'b0;
        bus.instr_done  = 1'b0;
        bus.int_ack     = 1'b0;
        bus.dev_req     = 8'h00;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_int_req", 32'(bus.int_req), 0);
        chk("rst_int_ena", 32'(bus.int_ena), 0);
        chk("rst_int_inh", 32'(bus.int_inh), 0);
        chk("rst_skip", 32'(bus.skip), 0);
        chk("rst_caf_clr", 32'(bus.caf_clr), 0);
        chk("rst_irq_valid", 32'(bus.irq_valid), 0);
        chk("rst_irq_id", 32'(bus.irq_id), 0);

        // ION delay: enable only after the next instruction's instr_done
        iot_step(12'o6001, 1'b1);
        chk("ion_armed_ena", 32'(bus.int_ena), 0);
        cyc();
        cyc();
        chk("ion_wait_ena", 32'(bus.int_ena), 0);
        done_step(12'o1234);
        chk("ion_on_ena", 32'(bus.int_ena), 1);

        // SKON while on: skip one cycle, then off
        iot_step(12'o6000, 1'b1);
        chk("skon_skip", 32'(bus.skip), 1);
        chk("skon_ena_off", 32'(bus.int_ena), 0);
        cyc();
        chk("skon_skip_end", 32'(bus.skip), 0);

        // ION then IOF before next instr_done
        iot_step(12'o6001, 1'b1);
        iot_step(12'o6002, 1'b1);
        chk("iof_ena", 32'(bus.int_ena), 0);
        done_step(12'o1234);
        chk("iof_stays_off", 32'(bus.int_ena), 0);

        // SKON while only armed does not skip
        iot_step(12'o6001, 1'b1);
        iot_step(12'o6000, 1'b1);
        chk("skon_armed_skip", 32'(bus.skip), 0);
        done_step(12'o1234);
        chk("skon_armed_off", 32'(bus.int_ena), 0);

        // Request path with masked bit 3
        bus.dev_req = 8'b0010_1000;
        cyc();
        chk("req_int_req", 32'(bus.int_req), 1);
        chk("req_irq_id", 32'(bus.irq_id), 5);
        chk("req_irq_valid", 32'(bus.irq_valid), 1);
        iot_step(12'o6003, 1'b1);
        chk("srq_skip", 32'(bus.skip), 1);
        bus.dev_req = 8'h84;
        cyc();
        chk("req_low_id", 32'(bus.irq_id), 2);
        bus.dev_req = 8'h08;
        cyc();
        chk("mask_int_req", 32'(bus.int_req), 0);
        chk("mask_irq_valid", 32'(bus.irq_valid), 0);
        chk("mask_irq_id", 32'(bus.irq_id), 0);
        iot_step(12'o6003, 1'b1);
        chk("srq_noskip", 32'(bus.skip), 0);
        bus.dev_req = 8'h00;

        // Inhibit set by CIF/CDI, cleared by JMP/JMS completion
        iot_step(12'o6212, 1'b1);
        chk("cif_inh", 32'(bus.int_inh), 1);
        done_step(12'o1234);
        chk("inh_hold", 32'(bus.int_inh), 1);
        done_step(12'o5200);
        chk("jmp_clr_inh", 32'(bus.int_inh), 0);
        iot_step(12'o6213, 1'b1);
        chk("cdi_inh", 32'(bus.int_inh), 1);
        done_step(12'o4100);
        chk("jms_clr_inh", 32'(bus.int_inh), 0);

        // int_ack beats a coincident CIF
        bus.int_ack = 1'b1;
        iot_step(12'o6212, 1'b1);
        bus.int_ack = 1'b0;
        chk("ack_cif_inh", 32'(bus.int_inh), 0);

        // int_ack beats a coincident ION
        go_ion();
        chk("ack_pre_ena", 32'(bus.int_ena), 1);
        bus.int_ack = 1'b1;
        iot_step(12'o6001, 1'b1);
        bus.int_ack = 1'b0;
        chk("ack_ena", 32'(bus.int_ena), 0);
        done_step(12'o1234);
        chk("ack_not_armed", 32'(bus.int_ena), 0);

        // CAF from ION with inhibit set
        go_ion();
        iot_step(12'o6212, 1'b1);
        chk("caf_pre_inh", 32'(bus.int_inh), 1);
        chk("caf_pre_ena", 32'(bus.int_ena), 1);
        iot_step(12'o6007, 1'b1);
        chk("caf_ena", 32'(bus.int_ena), 0);
        chk("caf_inh", 32'(bus.int_inh), 0);
        chk("caf_pulse", 32'(bus.caf_clr), 1);
        cyc();
        chk("caf_pulse_end", 32'(bus.caf_clr), 0);

        // Reset drops a pending skip and leaves ION
        go_ion();
        reset = 1'b1;
        iot_step(12'o6000, 1'b1);
        reset = 1'b0;
        chk("rst_mid_skip", 32'(bus.skip), 0);
        chk("rst_mid_ena", 32'(bus.int_ena), 0);

        // Reset while armed
        iot_step(12'o6001, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        done_step(12'o1234);
        chk("rst_armed_ena", 32'(bus.int_ena), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Owns the CPU interrupt system that feeds the major-state sequencer.
- Combines masked device request lines into int_req and runs the ION/IOF enable state machine, including the one-instruction ION delay.
- Tracks int_inh from CIF/CDI until the next JMP/JMS completes.
- Decodes the processor IOTs 6000–6007 and 62N2/62N3, returning skip and clear pulses to the datapath.

Parameters:
- NDEV, 8, number of device request inputs (1–16).
- DEV_MASK, all ones (NDEV bits), static per-device enable; bit i set means dev_req[i] may interrupt.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- instruction  in  [0:11]  current instruction register (bit 0 = MSB)
- iot_exec  in  1  one-cycle pulse while instruction holds an executing IOT
- instr_done  in  1  one-cycle pulse in the last cycle of every instruction, including the IOT's own (may coincide with iot_exec)
- int_ack  in  1  one-cycle pulse when the sequencer grants an interrupt (enters E0 with int_in_prog)
- dev_req  in  NDEV  level device flags
- int_req  out  1  registered OR of (dev_req & DEV_MASK)
- int_ena  out  1  interrupt system on
- int_inh  out  1  interrupt inhibit (CIF/CDI pending)
- skip  out  1  one-cycle skip pulse
- caf_clr  out  1  one-cycle clear-all-flags pulse to devices
- irq_id  out  4  index of lowest-numbered active masked request
- irq_valid  out  1  irq_id is meaningful

Behaviour:
Reset values:
- int_req=0, int_ena=0, int_inh=0, skip=0, caf_clr=0, irq_id=0, irq_valid=0; enable FSM in IOFF.

Request path (1-cycle registered latency, no latching):
- masked = dev_req & DEV_MASK.
- int_req <= |masked.
- irq_valid <= |masked.
- irq_id <= lowest set index of masked, or 0 if none.

Enable FSM (states IOFF, ARMED, ION); int_ena = (state==ION):
- IOFF: ION (6001) -> ARMED.
- ARMED: the first instr_done strictly after the cycle that executed ION -> ION. An instr_done coincident with the ION's iot_exec does not count.
- ION, or ION executed while ARMED: no change.
- IOF (6002): -> IOFF from any state, effective next cycle.
- SKON (6000): skip if state==ION (ARMED does not count); then -> IOFF.
- int_ack: -> IOFF; int_inh <= 0.
- CAF (6007): -> IOFF; int_inh <= 0; caf_clr pulses 1 cycle.

Priority when events coincide in one cycle:
1. reset
2. int_ack
3. iot_exec decode
4. instr_done

Other IOT decode (only when iot_exec=1):
- SRQ 6003: skip if int_req (registered value).
- GTF/RTF/SGT (6004–6006): no effect in this block.
- skip <= 1 in the cycle after iot_exec when the skip condition holds; otherwise skip=0.

Inhibit:
- Set: iot_exec with instruction[0:5]=62 (octal) and instruction[9:11] = 010 (CIF) or 011 (CDI).
- Clear: instr_done with instruction[0:2] = 100 (JMS) or 101 (JMP).
- Clear also on int_ack, CAF, or reset.
- If set and clear occur in the same cycle, clear wins. They cannot coincide legally; the bench checks deterministic clear.

Reset mid-operation:
- ARMED or ION returns to IOFF.
- Pending skip or caf_clr pulse is dropped.

Test Plan:
- Reset then dev_req=8'h00 -> int_req=0, int_ena=0, skip=0, irq_valid=0.
- ION: iot_exec+instr_done with 12'o6001, next instruction's instr_done 3 cycles later -> int_ena stays 0 until the cycle after that instr_done, then 1.
- ION then IOF before the next instr_done -> int_ena never rises; state IOFF.
- int_ena=1, SKON 12'o6000 -> skip=1 for exactly 1 cycle, int_ena=0 the next cycle.
- dev_req=8'b0010_1000, DEV_MASK=8'hF7 -> one cycle later int_req=1, irq_id=5, irq_valid=1. SRQ 12'o6003 -> skip=1.
- CIF 12'o6212 -> int_inh=1. Non-jump instr_done -> int_inh stays 1. JMP (12'o5200) instr_done -> int_inh=0 next cycle.
- int_ena=1 with int_ack and iot_exec ION in the same cycle -> state IOFF (ack wins).
- CAF 12'o6007 from ION with int_inh=1 -> int_ena=0, int_inh=0, caf_clr one 1-cycle pulse.
